// File: rtl/vga_capture.sv
// vga_capture: DE-timed VGA capture with frame-format check and lock FSM.
// Pixels are emitted only once two consecutive frames match H_ACTIVE x V_ACTIVE.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        rgb_valid,
  input  logic [15:0] rgb,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        frame_start,
  output logic        locked,
  output logic        fmt_err,
  output logic [11:0] meas_h_active,
  output logic [11:0] meas_v_active
);
  typedef enum logic [1:0] {UNLOCK, MEASURE, LOCKED} state_t;
  state_t r_state, w_next;
  logic        r_hs, r_vs, r_vs_d, r_de, r_de_d;
  logic [15:0] r_rgb;
  logic [11:0] r_x, r_y, r_hlen;
  logic        r_first, r_mis;
  logic        w_vs_edge, w_fall, w_pass, w_check, w_unused;
  assign w_vs_edge = (r_vs == SYNC_POL) && (r_vs_d != SYNC_POL);
  assign w_fall    = r_de_d && !r_de;
  // a DE still high at the vsync edge means the last line was cut short
  assign w_pass    = !r_mis && !r_de && (r_hlen == 12'(H_ACTIVE)) && (r_y == 12'(V_ACTIVE));
  assign w_check   = w_vs_edge && (r_state != UNLOCK);
  assign w_unused  = r_hs;
  assign locked    = (r_state == LOCKED);
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      {r_hs, r_vs, r_vs_d, r_de, r_de_d} <= '0;
      r_rgb <= '0;
    end else begin
      r_hs   <= hsync;
      r_vs   <= vsync;
      r_vs_d <= r_vs;
      r_de   <= rgb_valid;
      r_de_d <= r_de;
      r_rgb  <= rgb;
    end
  end
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_x     <= '0;
      r_y     <= '0;
      r_hlen  <= '0;
      r_first <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_x <= !r_de ? 12'd0 : (r_x == 12'hFFF) ? r_x : r_x + 12'd1;
      if (w_vs_edge) begin
        r_y     <= '0;
        r_hlen  <= '0;
        r_first <= 1'b0;
        r_mis   <= 1'b0;
      end else if (w_fall) begin
        if (r_y != 12'hFFF) r_y <= r_y + 12'd1;
        if (!r_first) begin
          r_hlen  <= r_x;
          r_first <= 1'b1;
        end else if (r_x != r_hlen) begin
          r_mis <= 1'b1;
        end
      end
    end
  end
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state       <= UNLOCK;
      pix_valid     <= 1'b0;
      pix_data      <= '0;
      pix_x         <= '0;
      pix_y         <= '0;
      frame_start   <= 1'b0;
      fmt_err       <= 1'b0;
      meas_h_active <= '0;
      meas_v_active <= '0;
    end else begin
      r_state     <= w_next;
      pix_valid   <= r_de && (r_state == LOCKED);
      pix_data    <= r_rgb;
      pix_x       <= r_x;
      pix_y       <= r_y;
      frame_start <= w_vs_edge;
      fmt_err     <= w_check && !w_pass;
      if (w_check) begin
        meas_h_active <= r_hlen;
        meas_v_active <= r_y;
      end
    end
  end
  always_comb begin
    w_next = r_state;
    if (w_vs_edge)
      w_next = (r_state == UNLOCK) ? MEASURE : w_pass ? LOCKED : (r_state == MEASURE) ? MEASURE : UNLOCK;
  end
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: frame-scenario table plus randomized pixel scoreboard for vga_capture.
module tb_vga_capture;
  localparam int HA = 16;
  localparam int VA = 8;
  logic        vga_clk = 1'b0;
  logic        sys_rst_n, hsync, vsync, rgb_valid;
  logic [15:0] rgb;
  logic        pix_valid, frame_start, locked, fmt_err;
  logic [15:0] pix_data;
  logic [11:0] pix_x, pix_y, meas_h_active, meas_v_active;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct { int hl, nl, bl, blen, tail, lat, efmt, elock, emh, emv; } row_t;
  typedef struct { logic [15:0] d; int x; int y; } pix_t;
  row_t tbl[14];
  pix_t q[$];
  bit   m_lock = 1'b0;
  int   m_x = 0;
  int   m_y = 0;
  vga_capture #(.H_ACTIVE(HA), .V_ACTIVE(VA), .SYNC_POL(1'b1)) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .hsync(hsync), .vsync(vsync),
    .rgb_valid(rgb_valid), .rgb(rgb), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .locked(locked),
    .fmt_err(fmt_err), .meas_h_active(meas_h_active), .meas_v_active(meas_v_active)
  );
  always #5 vga_clk = ~vga_clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  function automatic logic [15:0] rnd();
    return 16'($urandom);
  endfunction
  task automatic cyc(input logic v, input logic de, input logic [15:0] d);
    vsync = v;
    rgb_valid = de;
    rgb = d;
    hsync = 1'($urandom);
    @(posedge vga_clk);
    #1;
  endtask
  // every emitted pixel must match the next one the bench drove while locked
  always @(negedge vga_clk) begin
    pix_t e;
    if (pix_valid) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pix_extra: got pixel x=%0d y=%0d, required no pixel", pix_x, pix_y);
      end else begin
        e = q.pop_front();
        chk("pix_data", pix_data, e.d);
        chk("pix_x", pix_x, e.x);
        chk("pix_y", pix_y, e.y);
      end
    end
  end
  task automatic line(input int len, input bit lat);
    for (int p = 0; p < len; p++) begin
      logic [15:0] d;
      d = (lat && p == 0) ? 16'hF800 : rnd();
      cyc(1'b0, 1'b1, d);
      if (m_lock) q.push_back('{d, p, m_y});
      if (lat && p == 0) chk("lat_n1_valid", pix_valid, 0);
      if (lat && p == 1) begin
        chk("lat_n2_valid", pix_valid, 1);
        chk("lat_n2_data", pix_data, 16'hF800);
      end
    end
    m_y++;
  endtask
  task automatic frame(input int hl, input int nl, input int bl, input int blen, input int tail, input int lat);
    for (int l = 0; l < nl; l++) begin
      line((l == bl) ? blen : hl, lat != 0 && l == 0);
      repeat ($urandom_range(3, 8)) cyc(1'b0, 1'b0, rnd());
    end
    repeat (3) cyc(1'b0, 1'b0, rnd());
    for (int p = 0; p < tail; p++) begin
      logic [15:0] d;
      d = rnd();
      cyc(1'b0, 1'b1, d);
      if (m_lock) q.push_back('{d, p, m_y});
    end
    m_x = tail;
  endtask
  task automatic vsync_pulse(input bit dh, input int efmt, input int elock, input int emh, input int emv);
    logic [15:0] d;
    d = rnd();
    cyc(1'b1, dh, d);
    if (dh && m_lock) q.push_back('{d, m_x, m_y});
    cyc(1'b1, 1'b0, rnd());
    chk("frame_start", frame_start, 1);
    chk("fmt_err", fmt_err, efmt);
    chk("locked", locked, elock);
    if (emh >= 0) begin
      chk("meas_h", meas_h_active, emh);
      chk("meas_v", meas_v_active, emv);
    end
    cyc(1'b1, 1'b0, rnd());
    chk("frame_start_off", frame_start, 0);
    chk("fmt_err_off", fmt_err, 0);
    chk("q_drained", q.size(), 0);
    m_lock = elock != 0;
    m_y = 0;
    repeat ($urandom_range(2, 5)) cyc(1'b0, 1'b0, rnd());
  endtask
  initial begin
    sys_rst_n = 1'b0;
    vsync = 1'b0;
    hsync = 1'b0;
    rgb_valid = 1'b0;
    rgb = '0;
    // hl, nl, bl, blen, tail, lat | expected at this row's vsync: fmt, locked, meas_h, meas_v
    tbl[0]  = '{HA, VA,   -1, 0,      0, 0, 0, 0, -1,     -1};
    tbl[1]  = '{HA, VA,   -1, 0,      0, 0, 0, 1, HA,     VA};
    tbl[2]  = '{HA, VA,    3, HA - 1, 0, 0, 0, 1, HA,     VA};
    tbl[3]  = '{HA, VA,   -1, 0,      0, 0, 1, 0, HA,     VA};
    tbl[4]  = '{HA, VA - 1, -1, 0,    0, 0, 0, 0, -1,     -1};
    tbl[5]  = '{HA, VA,   -1, 0,      0, 0, 1, 0, HA,     VA - 1};
    tbl[6]  = '{HA, VA,   -1, 0,      5, 0, 0, 1, HA,     VA};
    tbl[7]  = '{HA, VA,   -1, 0,      0, 0, 1, 0, HA,     VA};
    tbl[8]  = '{HA, 0,    -1, 0,      0, 0, 0, 0, -1,     -1};
    tbl[9]  = '{HA, VA,   -1, 0,      0, 0, 1, 0, 0,      0};
    tbl[10] = '{HA + 1, VA, -1, 0,    0, 0, 0, 1, HA,     VA};
    tbl[11] = '{HA, VA,   -1, 0,      0, 0, 1, 0, HA + 1, VA};
    tbl[12] = '{HA, VA,   -1, 0,      0, 0, 0, 0, -1,     -1};
    tbl[13] = '{HA, VA,   -1, 0,      0, 1, 0, 1, HA,     VA};
    repeat (3) @(posedge vga_clk);
    #1;
    chk("rst_pix", {pix_valid, pix_data, pix_x}, 0);
    chk("rst_ctl", {pix_y, frame_start, locked, fmt_err}, 0);
    chk("rst_meas", {meas_h_active, meas_v_active}, 0);
    sys_rst_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, rnd());
    frame(HA, 3, -1, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      vsync_pulse(i > 0 && tbl[i - 1].tail > 0, tbl[i].efmt, tbl[i].elock, tbl[i].emh, tbl[i].emv);
      frame(tbl[i].hl, tbl[i].nl, tbl[i].bl, tbl[i].blen, tbl[i].tail, tbl[i].lat);
    end
    for (int p = 0; p < 5; p++) begin
      logic [15:0] d;
      d = rnd();
      cyc(1'b0, 1'b1, d);
      q.push_back('{d, p, m_y});
    end
    sys_rst_n = 1'b0;
    #1;
    q.delete();
    m_lock = 1'b0;
    chk("arst_pix", {pix_valid, pix_data, pix_x}, 0);
    chk("arst_ctl", {pix_y, frame_start, locked, fmt_err}, 0);
    chk("arst_meas", {meas_h_active, meas_v_active}, 0);
    repeat (2) cyc(1'b0, 1'b1, rnd());
    sys_rst_n = 1'b1;
    repeat (HA - 7) cyc(1'b0, 1'b1, rnd());
    repeat (4) cyc(1'b0, 1'b0, rnd());
    frame(HA, 3, -1, 0, 0, 0);
    vsync_pulse(1'b0, 0, 0, -1, -1);
    frame(HA, VA, -1, 0, 0, 0);
    vsync_pulse(1'b0, 0, 1, HA, VA);
    frame(HA, VA, -1, 0, 0, 0);
    vsync_pulse(1'b0, 0, 1, HA, VA);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_capture.md
VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 H_ACTIVE, 640, expected active pixels per line (DE run length).
REQ-002 V_ACTIVE, 480, expected active lines per frame.
REQ-003 SYNC_POL, 1, level of hsync/vsync during sync pulse (1 = active high).
REQ-004 vga_clk  input  1  pixel clock; the only clock; all logic on rising edge.
REQ-005 sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 hsync  input  1  line sync from source.
REQ-007 vsync  input  1  frame sync from source.
REQ-008 rgb_valid  input  1  data enable; high on active pixels.
REQ-009 rgb  input  16  RGB565 pixel.
REQ-010 pix_valid  output  1  captured pixel strobe; only while locked.
REQ-011 pix_data  output  16  captured pixel, RGB565.
REQ-012 pix_x  output  12  column of pix_data, 0-based.
REQ-013 pix_y  output  12  row of pix_data, 0-based.
REQ-014 frame_start  output  1  one-cycle pulse at each active vsync edge.
REQ-015 locked  output  1  high while incoming timing matches H_ACTIVE/V_ACTIVE.
REQ-016 fmt_err  output  1  one-cycle pulse when a frame fails the check.
REQ-017 meas_h_active  output  12  DE run length of first line of last complete frame.
REQ-018 meas_v_active  output  12  DE line count of last complete frame.

Function
REQ-019 All inputs SHALL be registered once (stage S1); edge detection and counters SHALL operate on S1 values.
REQ-020 pix_valid, pix_data, pix_x, pix_y SHALL be registered from S1: latency exactly 2 cycles from input to output.
REQ-021 Active vsync edge: S1 vsync transitions to SYNC_POL; frame_start SHALL pulse 1 cycle, 2 cycles after that input edge.
REQ-022 x counter: +1 per S1 DE-high cycle, cleared while DE low; saturates at 4095.
REQ-023 y counter: +1 on each S1 DE falling edge, cleared on active vsync edge; saturates at 4095.
REQ-024 h_len SHALL latch x count at the first DE falling edge of a frame; any later line with different run length SHALL set a per-frame mismatch flag.
REQ-025 Active vsync edge while S1 DE high (truncated line) SHALL set mismatch for the frame ending at that edge.
REQ-026 Frame check at each active vsync edge: pass iff mismatch clear, h_len == H_ACTIVE, y count == V_ACTIVE; then h_len -> meas_h_active, y count -> meas_v_active, mismatch cleared.
REQ-027 FSM states UNLOCK, MEASURE, LOCKED; reset state UNLOCK.
REQ-028 UNLOCK: on active vsync edge -> MEASURE (no check; partial frame discarded).
REQ-029 MEASURE: at vsync edge, pass -> LOCKED; fail -> stay MEASURE, fmt_err pulse.
REQ-030 LOCKED: at vsync edge, pass -> stay; fail -> UNLOCK, fmt_err pulse.
REQ-031 locked SHALL be high exactly in LOCKED, updated in the same cycle as frame_start.
REQ-032 pix_valid = S1 DE AND state LOCKED; pixels of the frame that caused the LOCKED->UNLOCK transition were already emitted and are not retracted.
REQ-033 hsync is sampled for polarity-consistent edge only; it SHALL not affect counters (DE-based timing).
REQ-034 Frame with zero DE lines SHALL fail (y count 0 != V_ACTIVE).

Reset
REQ-035 On sys_rst_n low, immediately: all outputs 0, counters 0, mismatch 0, state UNLOCK, S1 registers 0.
REQ-036 Reset release mid-frame SHALL behave as UNLOCK: first active vsync edge starts MEASURE, no fmt_err for the partial frame.

Verification
REQ-037 Two nominal 640x480 frames after reset -> 1st vsync: MEASURE, no fmt_err; 2nd vsync: locked=1, meas=640/480; 3rd frame pixels emit with pix_x 0..639, pix_y 0..479.
REQ-038 Locked, one line with 639 DE cycles -> at next vsync fmt_err pulse, locked=0, state UNLOCK.
REQ-039 Frame with 479 lines in MEASURE -> fmt_err pulse, meas_v_active=479, stays unlocked; next good frame -> locked=1.
REQ-040 Latency: DE high on pixel value 16'hF800 at cycle n -> pix_valid=1, pix_data=16'hF800 at cycle n+2.
REQ-041 vsync edge while DE high while locked -> fmt_err, locked=0.
REQ-042 Assert sys_rst_n low mid-line while locked -> all outputs 0 asynchronously; after release, two good frames required before locked=1.
